wb_commit: RTL and testbench

Writeback/commit stage of the 5-stage MIPS pipeline, between the MEM stage and the CP0 register file. Each cycle it holds at most one instruction. It either retires the instruction (regfile write, mtc0 write, mfc0 read-back) or turns it into a precise exception or eret. It also samples pending interrupts and drives the pipeline-wide flush and redirect PC.

---
 rtl/wb_commit.sv | 162 ++++++++++++++++
 tb/tb_wb_commit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Writeback/commit stage: retires the instruction in WB or turns it into a
// precise exception/eret, samples interrupts and drives the pipeline flush.
module wb_commit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_bd,
    input  logic        ms_ex,
    input  logic [4:0]  ms_excode,
    input  logic        ms_eret,
    input  logic        ms_mtc0,
    input  logic        ms_mfc0,
    input  logic [7:0]  ms_c0_addr,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic [31:0] c0_rdata,
    input  logic [31:0] c0_epc,
    input  logic        c0_status_ie,
    input  logic        c0_status_exl,
    input  logic [7:0]  c0_status_im,
    input  logic [7:0]  c0_cause_ip,
    output logic        wb_ex,
    output logic        wb_bd,
    output logic        eret_flush,
    output logic        mtc0_we,
    output logic [4:0]  wb_excode,
    output logic [31:0] wb_pc,
    output logic [7:0]  c0_addr,
    output logic [31:0] c0_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam logic [31:0] EX_VEC = 32'hbfc00380;

    logic        r_ws_valid;
    logic        r_int_q;
    logic [31:0] r_ws_pc;
    logic        r_ws_bd;
    logic        r_ws_ex;
    logic [4:0]  r_ws_excode;
    logic        r_ws_eret;
    logic        r_ws_mtc0;
    logic        r_ws_mfc0;
    logic [7:0]  r_ws_c0_addr;
    logic        r_ws_rf_we;
    logic [4:0]  r_ws_dest;
    logic [31:0] r_ws_result;

    logic        w_accept;
    logic        w_int_pend;
    logic        w_int_take;
    logic        w_ex_take;
    logic        w_eret_take;
    logic        w_commit;
    logic        w_flush;
    logic        w_rf_we;
    logic [31:0] w_rf_wdata;
    logic [31:0] w_flush_pc;

    assign ws_allowin = 1'b1;
    assign w_accept   = ms_to_ws_valid & ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            r_ws_valid <= ms_to_ws_valid & ~w_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_pc      <= 32'h0;
            r_ws_bd      <= 1'b0;
            r_ws_ex      <= 1'b0;
            r_ws_excode  <= 5'h0;
            r_ws_eret    <= 1'b0;
            r_ws_mtc0    <= 1'b0;
            r_ws_mfc0    <= 1'b0;
            r_ws_c0_addr <= 8'h0;
            r_ws_rf_we   <= 1'b0;
            r_ws_dest    <= 5'h0;
            r_ws_result  <= 32'h0;
        end else if (w_accept) begin
            r_ws_pc      <= ms_pc;
            r_ws_bd      <= ms_bd;
            r_ws_ex      <= ms_ex;
            r_ws_excode  <= ms_excode;
            r_ws_eret    <= ms_eret;
            r_ws_mtc0    <= ms_mtc0;
            r_ws_mfc0    <= ms_mfc0;
            r_ws_c0_addr <= ms_c0_addr;
            r_ws_rf_we   <= ms_rf_we;
            r_ws_dest    <= ms_dest;
            r_ws_result  <= ms_result;
        end
    end

    // A flush this cycle masks the sample so EXL can rise before a re-take.
    assign w_int_pend = c0_status_ie & ~c0_status_exl
                      & (|(c0_status_im & c0_cause_ip));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_int_q <= 1'b0;
        end else begin
            r_int_q <= w_int_pend & ~wb_ex & ~eret_flush;
        end
    end

    assign w_int_take  = r_ws_valid & r_int_q;
    assign w_ex_take   = w_int_take | (r_ws_valid & r_ws_ex);
    assign w_eret_take = r_ws_valid & ~w_ex_take & r_ws_eret;
    assign w_commit    = r_ws_valid & ~w_ex_take & ~w_eret_take;
    assign w_flush     = w_ex_take | w_eret_take;

    always_comb begin
        w_flush_pc = 32'h0;
        unique case (1'b1)
            w_ex_take:   w_flush_pc = EX_VEC;
            w_eret_take: w_flush_pc = c0_epc;
            default:     w_flush_pc = 32'h0;
        endcase
    end

    assign w_rf_we    = w_commit & r_ws_rf_we;
    assign w_rf_wdata = r_ws_mfc0 ? c0_rdata : r_ws_result;

    assign wb_ex      = w_ex_take;
    assign wb_excode  = w_int_take ? 5'h00 : r_ws_excode;
    assign wb_bd      = r_ws_bd;
    assign wb_pc      = r_ws_pc;
    assign eret_flush = w_eret_take;

    assign mtc0_we    = w_commit & r_ws_mtc0;
    assign c0_addr    = r_ws_c0_addr;
    assign c0_wdata   = r_ws_result;

    assign rf_we      = w_rf_we;
    assign rf_waddr   = r_ws_dest;
    assign rf_wdata   = w_rf_wdata;

    assign flush      = w_flush;
    assign flush_pc   = w_flush_pc;

    assign debug_wb_pc       = r_ws_pc;
    assign debug_wb_rf_wen   = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_ws_dest;
    assign debug_wb_rf_wdata = w_rf_wdata;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed plan steps, then random traffic against a
// per-instruction reference model of retire/exception/eret/interrupt rules.
module tb_wb_commit;

    logic        clk;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_bd;
    logic        ms_ex;
    logic [4:0]  ms_excode;
    logic        ms_eret;
    logic        ms_mtc0;
    logic        ms_mfc0;
    logic [7:0]  ms_c0_addr;
    logic        ms_rf_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic [31:0] c0_rdata;
    logic [31:0] c0_epc;
    logic        c0_status_ie;
    logic        c0_status_exl;
    logic [7:0]  c0_status_im;
    logic [7:0]  c0_cause_ip;
    logic        wb_ex;
    logic        wb_bd;
    logic        eret_flush;
    logic        mtc0_we;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc;
    logic [7:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_commit dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex(ms_ex),
        .ms_excode(ms_excode), .ms_eret(ms_eret),
        .ms_mtc0(ms_mtc0), .ms_mfc0(ms_mfc0),
        .ms_c0_addr(ms_c0_addr), .ms_rf_we(ms_rf_we),
        .ms_dest(ms_dest), .ms_result(ms_result),
        .c0_rdata(c0_rdata), .c0_epc(c0_epc),
        .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
        .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip),
        .wb_ex(wb_ex), .wb_bd(wb_bd), .eret_flush(eret_flush),
        .mtc0_we(mtc0_we), .wb_excode(wb_excode), .wb_pc(wb_pc),
        .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush(flush), .flush_pc(flush_pc),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic        eret;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  c0a;
        logic        rfwe;
        logic [4:0]  dest;
        logic [31:0] res;
    } ins_t;

    // Model: the instruction occupying WB (if any) and whether an interrupt
    // was found pending (and not masked by a flush) in the previous cycle.
    logic m_has;
    ins_t m_ins;
    logic m_irq;

    int tests;
    int failed;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_has = 1'b0;
        m_ins = '0;
        m_irq = 1'b0;
    endtask

    task automatic clr_ms();
        ms_to_ws_valid = 1'b0;
        ms_pc = 32'h0; ms_bd = 1'b0; ms_ex = 1'b0; ms_excode = 5'h0;
        ms_eret = 1'b0; ms_mtc0 = 1'b0; ms_mfc0 = 1'b0;
        ms_c0_addr = 8'h0; ms_rf_we = 1'b0; ms_dest = 5'h0;
        ms_result = 32'h0;
    endtask

    task automatic alu(input logic [31:0] pc, input logic [4:0] d,
                       input logic [31:0] r);
        clr_ms();
        ms_to_ws_valid = 1'b1;
        ms_pc = pc; ms_rf_we = 1'b1; ms_dest = d; ms_result = r;
    endtask

    // Check this cycle's outputs against the model, then advance one edge.
    task automatic tick();
        logic take_int, take_ex, take_eret, retire, e_rf, e_mt;
        logic [31:0] e_fpc, e_wd;
        ins_t nxt;
        #1;
        take_int  = m_has & m_irq;
        take_ex   = take_int | (m_has & m_ins.ex);
        take_eret = m_has & ~take_ex & m_ins.eret;
        retire    = m_has & ~take_ex & ~take_eret;
        e_rf      = retire & m_ins.rfwe;
        e_mt      = retire & m_ins.mtc0;
        e_fpc     = take_ex ? 32'hbfc00380 : (take_eret ? c0_epc : 32'h0);
        e_wd      = m_ins.mfc0 ? c0_rdata : m_ins.res;
        chk("allowin", {31'h0, ws_allowin}, 32'h1);
        chk("wb_ex", {31'h0, wb_ex}, {31'h0, take_ex});
        chk("eret_flush", {31'h0, eret_flush}, {31'h0, take_eret});
        chk("flush", {31'h0, flush}, {31'h0, take_ex | take_eret});
        chk("flush_pc", flush_pc, e_fpc);
        chk("rf_we", {31'h0, rf_we}, {31'h0, e_rf});
        chk("mtc0_we", {31'h0, mtc0_we}, {31'h0, e_mt});
        chk("wb_pc", wb_pc, m_ins.pc);
        chk("wb_bd", {31'h0, wb_bd}, {31'h0, m_ins.bd});
        chk("c0_addr", {24'h0, c0_addr}, {24'h0, m_ins.c0a});
        chk("c0_wdata", c0_wdata, m_ins.res);
        chk("rf_waddr", {27'h0, rf_waddr}, {27'h0, m_ins.dest});
        chk("rf_wdata", rf_wdata, e_wd);
        chk("dbg_pc", debug_wb_pc, m_ins.pc);
        chk("dbg_wen", {28'h0, debug_wb_rf_wen}, {28'h0, {4{e_rf}}});
        chk("dbg_wnum", {27'h0, debug_wb_rf_wnum}, {27'h0, m_ins.dest});
        chk("dbg_wdata", debug_wb_rf_wdata, e_wd);
        if (take_ex)
            chk("wb_excode", {27'h0, wb_excode},
                {27'h0, take_int ? 5'h0 : m_ins.excode});
        nxt = '{ms_pc, ms_bd, ms_ex, ms_excode, ms_eret, ms_mtc0, ms_mfc0,
                ms_c0_addr, ms_rf_we, ms_dest, ms_result};
        if (reset) begin
            model_clear();
        end else begin
            m_irq = c0_status_ie & ~c0_status_exl
                  & (|(c0_status_im & c0_cause_ip))
                  & ~take_ex & ~take_eret;
            m_has = ms_to_ws_valid & ~(take_ex | take_eret);
            if (ms_to_ws_valid) m_ins = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b1;
        clr_ms();
        c0_rdata = 32'h0; c0_epc = 32'h0;
        c0_status_ie = 1'b0; c0_status_exl = 1'b0;
        c0_status_im = 8'h0; c0_cause_ip = 8'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;
        tick();

        alu(32'hbfc00000, 5'd1, 32'h11); tick();
        alu(32'hbfc00004, 5'd2, 32'h22); tick();
        alu(32'hbfc00008, 5'd3, 32'h33); tick();
        clr_ms(); tick();

        clr_ms();
        ms_to_ws_valid = 1'b1; ms_pc = 32'hbfc0000c; ms_mtc0 = 1'b1;
        ms_c0_addr = 8'h70; ms_result = 32'hbfc00100;
        tick();
        clr_ms();
        ms_to_ws_valid = 1'b1; ms_pc = 32'hbfc00010; ms_mfc0 = 1'b1;
        ms_c0_addr = 8'h70; ms_rf_we = 1'b1; ms_dest = 5'd4;
        tick();
        clr_ms();
        c0_rdata = 32'hbfc00100;
        tick();

        clr_ms();
        ms_to_ws_valid = 1'b1; ms_pc = 32'hbfc00010; ms_bd = 1'b1;
        ms_ex = 1'b1; ms_excode = 5'h08; ms_rf_we = 1'b1; ms_dest = 5'd5;
        ms_result = 32'hdead;
        tick();
        alu(32'hbfc00014, 5'd6, 32'h66); tick();
        clr_ms(); tick();

        clr_ms();
        ms_to_ws_valid = 1'b1; ms_pc = 32'hbfc00020; ms_eret = 1'b1;
        tick();
        clr_ms();
        c0_epc = 32'hbfc00200;
        tick();
        tick();

        c0_status_ie = 1'b1; c0_status_im = 8'h01; c0_cause_ip = 8'h01;
        alu(32'hbfc00040, 5'd7, 32'h77); tick();
        alu(32'hbfc00044, 5'd8, 32'h88); tick();
        c0_cause_ip = 8'h00;
        clr_ms(); tick();
        tick();

        clr_ms();
        ms_to_ws_valid = 1'b1; ms_pc = 32'hbfc00050; ms_ex = 1'b1;
        ms_excode = 5'h0c;
        tick();
        reset = 1'b1;
        alu(32'hbfc00054, 5'd9, 32'h99); tick();
        reset = 1'b0;
        clr_ms(); tick();

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            ms_to_ws_valid = ($urandom_range(0, 3) != 0);
            ms_pc = {$urandom_range(0, 32'hffff), 2'b00};
            ms_bd = $urandom_range(0, 1);
            ms_ex = ($urandom_range(0, 7) == 0);
            ms_excode = 5'($urandom_range(0, 31));
            ms_eret = ($urandom_range(0, 7) == 0);
            ms_mtc0 = ($urandom_range(0, 5) == 0);
            ms_mfc0 = ($urandom_range(0, 5) == 0);
            ms_c0_addr = 8'($urandom);
            ms_rf_we = $urandom_range(0, 1);
            ms_dest = 5'($urandom);
            ms_result = $urandom;
            c0_rdata = $urandom;
            c0_epc = $urandom;
            c0_status_ie = ($urandom_range(0, 3) != 0);
            c0_status_exl = ($urandom_range(0, 3) == 0);
            c0_status_im = 8'($urandom);
            c0_cause_ip = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
